pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC register.
- Generates ALU operand forwarding selects.
- Sequences multi-cycle data-memory waits with a timeout, and arbitrates priority between memory stall, branch flush, load-use stall and jump flush.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 60 ++++++
 rtl/pipeline_hazard_ctrl_forward_unit.sv | 48 ++++
 rtl/pipeline_hazard_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the 5-stage pipeline hazard controller.
//   hz_state_t : controller FSM state (RUN, MEM_WAIT)
//   fwd_sel_t  : ALU operand forwarding select
//                FWD_NONE  = register file value
//                FWD_MEMWB = value in the MEM/WB register
//                FWD_EXMEM = value in the EX/MEM register
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE  = 2'b00;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives register addresses / stage status and
//            receives enables, flushes, forwarding selects, error and counters
//   slave  : hazard controller side
// Parameters: BIT_SEL (register-address width), CNT_WIDTH (perf counter width)
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int BIT_SEL   = 5,
  parameter int CNT_WIDTH = 16
);
  import hazard_pkg::*;

  // Pipeline status into the controller
  logic [BIT_SEL-1:0]   rs_IFID;
  logic [BIT_SEL-1:0]   rt_IFID;
  logic [BIT_SEL-1:0]   rs_IDEX;
  logic [BIT_SEL-1:0]   rt_IDEX;
  logic                 MemRead_IDEX;
  logic                 RegWrite_EXMEM;
  logic [BIT_SEL-1:0]   dest_EXMEM;
  logic                 RegWrite_MEMWB;
  logic [BIT_SEL-1:0]   dest_MEMWB;
  logic                 branch_taken_EX;
  logic                 jump_ID;
  logic                 dmem_req;
  logic                 dmem_ready;

  // Controls back to the pipeline
  logic                 pc_en;
  logic                 ifid_en;
  logic                 idex_en;
  logic                 exmem_en;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 memwb_flush;
  fwd_sel_t             fwd_a;
  fwd_sel_t             fwd_b;
  logic                 mem_err;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;

  modport master (
    output rs_IFID, rt_IFID, rs_IDEX, rt_IDEX, MemRead_IDEX,
           RegWrite_EXMEM, dest_EXMEM, RegWrite_MEMWB, dest_MEMWB,
           branch_taken_EX, jump_ID, dmem_req, dmem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           memwb_flush, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_IFID, rt_IFID, rs_IDEX, rt_IDEX, MemRead_IDEX,
           RegWrite_EXMEM, dest_EXMEM, RegWrite_MEMWB, dest_MEMWB,
           branch_taken_EX, jump_ID, dmem_req, dmem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           memwb_flush, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// -----------------------------------------------------------------------------
// forward_unit
// Combinational ALU operand forwarding. The youngest producer (EX/MEM) wins
// over MEM/WB; register 0 is never forwarded.
// Ports:
//   rs_IDEX, rt_IDEX           : EX-stage source registers
//   RegWrite_EXMEM, dest_EXMEM : EX/MEM producer
//   RegWrite_MEMWB, dest_MEMWB : MEM/WB producer
//   fwd_a, fwd_b               : operand A/B source select
// -----------------------------------------------------------------------------
module forward_unit
  import hazard_pkg::*;
#(
  parameter int BIT_SEL = 5
) (
  input  logic [BIT_SEL-1:0] rs_IDEX,
  input  logic [BIT_SEL-1:0] rt_IDEX,
  input  logic               RegWrite_EXMEM,
  input  logic [BIT_SEL-1:0] dest_EXMEM,
  input  logic               RegWrite_MEMWB,
  input  logic [BIT_SEL-1:0] dest_MEMWB,
  output fwd_sel_t           fwd_a,
  output fwd_sel_t           fwd_b
);

  function automatic fwd_sel_t pick_src(input logic [BIT_SEL-1:0] src,
                                        input logic               rw_em,
                                        input logic [BIT_SEL-1:0] d_em,
                                        input logic               rw_mw,
                                        input logic [BIT_SEL-1:0] d_mw);
    fwd_sel_t sel;
    if (rw_em && (d_em != {BIT_SEL{1'b0}}) && (d_em == src)) begin
      sel = FWD_EXMEM;
    end else if (rw_mw && (d_mw != {BIT_SEL{1'b0}}) && (d_mw == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

  // Operand source selection for both ALU inputs
  always_comb begin
    fwd_a = pick_src(rs_IDEX, RegWrite_EXMEM, dest_EXMEM, RegWrite_MEMWB, dest_MEMWB);
    fwd_b = pick_src(rt_IDEX, RegWrite_EXMEM, dest_EXMEM, RegWrite_MEMWB, dest_MEMWB);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Stall/flush/forwarding controller for a 5-stage MIPS pipeline.
// State changes on the falling clock edge, matching the pipeline registers.
// Priority in RUN: memory stall > branch flush > load-use stall > jump flush.
// A memory access that stays unready for MEM_TIMEOUT frozen cycles is dropped,
// the freeze is released and the sticky mem_err flag is set.
// Ports:
//   clk : pipeline clock (falling edge active)
//   rst : asynchronous active-high reset
//   hz  : pipeline_hazard_ctrl_if.slave (all pipeline status and controls)
// Build option: define HAZARD_PERF_EN to get saturating stall_cnt/flush_cnt
// counters; otherwise both outputs are tied to zero.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int BIT_SEL     = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int             WCW       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

  hz_state_t      state_r;
  hz_state_t      next_state_s;
  logic [WCW-1:0] wait_cnt_r;
  logic [WCW-1:0] wait_cnt_nx_s;
  logic           mem_err_r;
  logic           set_err_s;
  logic           release_s;
  logic           load_use_s;

  logic           pc_en_s;
  logic           ifid_en_s;
  logic           idex_en_s;
  logic           exmem_en_s;
  logic           ifid_flush_s;
  logic           idex_flush_s;
  logic           memwb_flush_s;
  fwd_sel_t       fwd_a_s;
  fwd_sel_t       fwd_b_s;

  forward_unit #(.BIT_SEL(BIT_SEL)) u_forward_unit (
    .rs_IDEX        (hz.rs_IDEX),
    .rt_IDEX        (hz.rt_IDEX),
    .RegWrite_EXMEM (hz.RegWrite_EXMEM),
    .dest_EXMEM     (hz.dest_EXMEM),
    .RegWrite_MEMWB (hz.RegWrite_MEMWB),
    .dest_MEMWB     (hz.dest_MEMWB),
    .fwd_a          (fwd_a_s),
    .fwd_b          (fwd_b_s)
  );

  // Load in EX whose destination (rt) feeds the instruction in decode
  always_comb begin
    load_use_s = hz.MemRead_IDEX && (hz.rt_IDEX != {BIT_SEL{1'b0}}) &&
                 ((hz.rt_IDEX == hz.rs_IFID) || (hz.rt_IDEX == hz.rt_IFID));
  end

  // Mealy output decode, next state and wait-counter update
  always_comb begin
    pc_en_s       = 1'b1;
    ifid_en_s     = 1'b1;
    idex_en_s     = 1'b1;
    exmem_en_s    = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_flush_s  = 1'b0;
    memwb_flush_s = 1'b0;
    next_state_s  = state_r;
    wait_cnt_nx_s = wait_cnt_r;
    set_err_s     = 1'b0;
    release_s     = 1'b0;

    case (state_r)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ready) begin
          pc_en_s       = 1'b0;
          ifid_en_s     = 1'b0;
          idex_en_s     = 1'b0;
          exmem_en_s    = 1'b0;
          memwb_flush_s = 1'b1;
          next_state_s  = MEM_WAIT;
          wait_cnt_nx_s = WCW'(1);
        end else begin
          release_s     = 1'b1;
          wait_cnt_nx_s = {WCW{1'b0}};
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          release_s     = 1'b1;
          next_state_s  = RUN;
          wait_cnt_nx_s = {WCW{1'b0}};
        end else if (wait_cnt_r >= TIMEOUT_V) begin
          // Abort: drop the access, MEM/WB still receives a bubble
          release_s     = 1'b1;
          memwb_flush_s = 1'b1;
          set_err_s     = 1'b1;
          next_state_s  = RUN;
          wait_cnt_nx_s = {WCW{1'b0}};
        end else begin
          pc_en_s       = 1'b0;
          ifid_en_s     = 1'b0;
          idex_en_s     = 1'b0;
          exmem_en_s    = 1'b0;
          memwb_flush_s = 1'b1;
          wait_cnt_nx_s = wait_cnt_r + WCW'(1);
        end
      end
      default: begin
        next_state_s  = RUN;
        wait_cnt_nx_s = {WCW{1'b0}};
      end
    endcase

    // Lower priorities apply whenever the memory freeze is not holding
    if (release_s) begin
      if (hz.branch_taken_EX) begin
        ifid_flush_s = 1'b1;
        idex_flush_s = 1'b1;
      end else if (load_use_s) begin
        pc_en_s      = 1'b0;
        ifid_en_s    = 1'b0;
        idex_flush_s = 1'b1;
      end else if (hz.jump_ID) begin
        ifid_flush_s = 1'b1;
      end else begin
        ifid_flush_s = 1'b0;
      end
    end else begin
      ifid_flush_s = 1'b0;
    end

    // Reset forces every control low regardless of state
    if (rst) begin
      pc_en_s       = 1'b0;
      ifid_en_s     = 1'b0;
      idex_en_s     = 1'b0;
      exmem_en_s    = 1'b0;
      ifid_flush_s  = 1'b0;
      idex_flush_s  = 1'b0;
      memwb_flush_s = 1'b0;
    end else begin
      next_state_s  = next_state_s;
    end
  end

  // FSM state, wait counter and sticky memory error flag
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= RUN;
      wait_cnt_r <= {WCW{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_nx_s;
      mem_err_r  <= mem_err_r | set_err_s;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [CNT_WIDTH-1:0] flush_cnt_r;

  // Saturating stall / IF-ID flush event counters
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
      flush_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (!pc_en_s && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_WIDTH'(1);
      end
      if (ifid_flush_s && (flush_cnt_r != {CNT_WIDTH{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  assign hz.stall_cnt = stall_cnt_r;
  assign hz.flush_cnt = flush_cnt_r;
`else
  assign hz.stall_cnt = {CNT_WIDTH{1'b0}};
  assign hz.flush_cnt = {CNT_WIDTH{1'b0}};
`endif

  assign hz.pc_en       = pc_en_s;
  assign hz.ifid_en     = ifid_en_s;
  assign hz.idex_en     = idex_en_s;
  assign hz.exmem_en    = exmem_en_s;
  assign hz.ifid_flush  = ifid_flush_s;
  assign hz.idex_flush  = idex_flush_s;
  assign hz.memwb_flush = memwb_flush_s;
  assign hz.fwd_a       = rst ? FWD_NONE : fwd_a_s;
  assign hz.fwd_b       = rst ? FWD_NONE : fwd_b_s;
  assign hz.mem_err     = mem_err_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed plus randomized stimulus for pipeline_hazard_ctrl, checked against
// a rule-level reference model. Inputs change just after the falling (active)
// edge; outputs are checked at the rising edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  localparam int BIT_SEL     = 5;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_WIDTH   = 16;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst;

  pipeline_hazard_ctrl_if #(.BIT_SEL(BIT_SEL), .CNT_WIDTH(CNT_WIDTH)) hz ();

  pipeline_hazard_ctrl #(
    .BIT_SEL     (BIT_SEL),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: whether a memory access is being waited on, and
  // how many consecutive cycles the pipeline has been frozen for it.
  bit m_waiting;
  int m_frozen;
  bit m_err;
  int m_stall;
  int m_flush;

  // Expected outputs for the current cycle
  bit       e_pc, e_ifid_en, e_idex_en, e_exmem_en;
  bit       e_ifid_fl, e_idex_fl, e_memwb_fl;
  logic [1:0] e_fa, e_fb;
  bit       e_stall_mem, e_timeout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int src);
    if (hz.RegWrite_EXMEM && hz.dest_EXMEM != 0 && int'(hz.dest_EXMEM) == src) return 2'b10;
    if (hz.RegWrite_MEMWB && hz.dest_MEMWB != 0 && int'(hz.dest_MEMWB) == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_waiting = 1'b0;
    m_frozen  = 0;
    m_err     = 1'b0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  task automatic model_eval();
    bit lu;
    lu = hz.MemRead_IDEX && hz.rt_IDEX != 0 &&
         (hz.rt_IDEX == hz.rs_IFID || hz.rt_IDEX == hz.rt_IFID);
    e_timeout   = m_waiting && !hz.dmem_ready && (m_frozen >= MEM_TIMEOUT);
    e_stall_mem = !hz.dmem_ready && (m_waiting || hz.dmem_req) && !e_timeout;
    {e_pc, e_ifid_en, e_idex_en, e_exmem_en} = 4'b1111;
    {e_ifid_fl, e_idex_fl, e_memwb_fl}       = 3'b000;
    if (e_stall_mem) begin
      {e_pc, e_ifid_en, e_idex_en, e_exmem_en} = 4'b0000;
      e_memwb_fl = 1'b1;
    end else begin
      e_memwb_fl = e_timeout;
      if (hz.branch_taken_EX) begin
        e_ifid_fl = 1'b1;
        e_idex_fl = 1'b1;
      end else if (lu) begin
        e_pc      = 1'b0;
        e_ifid_en = 1'b0;
        e_idex_fl = 1'b1;
      end else if (hz.jump_ID) begin
        e_ifid_fl = 1'b1;
      end
    end
    e_fa = ref_fwd(int'(hz.rs_IDEX));
    e_fb = ref_fwd(int'(hz.rt_IDEX));
    if (rst) begin
      {e_pc, e_ifid_en, e_idex_en, e_exmem_en} = 4'b0000;
      {e_ifid_fl, e_idex_fl, e_memwb_fl}       = 3'b000;
      e_fa = 2'b00;
      e_fb = 2'b00;
    end
  endtask

  task automatic model_update();
    if (e_stall_mem) begin
      m_waiting = 1'b1;
      m_frozen  = m_frozen + 1;
    end else begin
      m_waiting = 1'b0;
      m_frozen  = 0;
    end
    if (e_timeout) m_err = 1'b1;
    if (!e_pc && m_stall < CNT_MAX) m_stall++;
    if (e_ifid_fl && m_flush < CNT_MAX) m_flush++;
  endtask

  // Check all outputs at the rising edge against the model
  task automatic settle(input string tag);
    int es, ef;
    @(posedge clk);
    if (rst) model_reset();
    model_eval();
`ifdef HAZARD_PERF_EN
    es = m_stall;
    ef = m_flush;
`else
    es = 0;
    ef = 0;
`endif
    chk({tag, ".pc_en"},       32'(hz.pc_en),       32'(e_pc));
    chk({tag, ".ifid_en"},     32'(hz.ifid_en),     32'(e_ifid_en));
    chk({tag, ".idex_en"},     32'(hz.idex_en),     32'(e_idex_en));
    chk({tag, ".exmem_en"},    32'(hz.exmem_en),    32'(e_exmem_en));
    chk({tag, ".ifid_flush"},  32'(hz.ifid_flush),  32'(e_ifid_fl));
    chk({tag, ".idex_flush"},  32'(hz.idex_flush),  32'(e_idex_fl));
    chk({tag, ".memwb_flush"}, 32'(hz.memwb_flush), 32'(e_memwb_fl));
    chk({tag, ".fwd_a"},       32'(hz.fwd_a),       32'(e_fa));
    chk({tag, ".fwd_b"},       32'(hz.fwd_b),       32'(e_fb));
    chk({tag, ".mem_err"},     32'(hz.mem_err),     32'(m_err));
    chk({tag, ".stall_cnt"},   32'(hz.stall_cnt),   32'(es));
    chk({tag, ".flush_cnt"},   32'(hz.flush_cnt),   32'(ef));
  endtask

  // Let the falling edge update state, then advance the model
  task automatic advance();
    @(negedge clk);
    #1;
    if (rst) model_reset();
    else model_update();
  endtask

  task automatic cycle(input string tag);
    settle(tag);
    advance();
  endtask

  task automatic clear_in();
    hz.rs_IFID = '0; hz.rt_IFID = '0; hz.rs_IDEX = '0; hz.rt_IDEX = '0;
    hz.MemRead_IDEX = 1'b0; hz.RegWrite_EXMEM = 1'b0; hz.dest_EXMEM = '0;
    hz.RegWrite_MEMWB = 1'b0; hz.dest_MEMWB = '0; hz.branch_taken_EX = 1'b0;
    hz.jump_ID = 1'b0; hz.dmem_req = 1'b0; hz.dmem_ready = 1'b1;
  endtask

  initial begin
    int hold;
    rst = 1'b1;
    clear_in();
    model_reset();

    // Reset values
    settle("reset");
    chk("reset.pc_en_zero", 32'(hz.pc_en), 32'd0);
    advance();
    rst = 1'b0;

    // Forwarding: EX/MEM wins, then MEM/WB, then none
    hz.RegWrite_EXMEM = 1'b1; hz.dest_EXMEM = 5'd8;
    hz.RegWrite_MEMWB = 1'b1; hz.dest_MEMWB = 5'd8;
    hz.rs_IDEX = 5'd8; hz.rt_IDEX = 5'd3;
    settle("fwd_both");
    chk("fwd_both.a_exmem", 32'(hz.fwd_a), 32'd2);
    chk("fwd_both.b_none",  32'(hz.fwd_b), 32'd0);
    advance();
    hz.dest_EXMEM = 5'd0;
    settle("fwd_memwb");
    chk("fwd_memwb.a", 32'(hz.fwd_a), 32'd1);
    advance();

    // Load-use: one bubble, then clears; rt=0 never stalls
    clear_in();
    hz.MemRead_IDEX = 1'b1; hz.rt_IDEX = 5'd5; hz.rs_IFID = 5'd5;
    settle("lu");
    chk("lu.pc_en", 32'(hz.pc_en), 32'd0);
    chk("lu.idex_flush", 32'(hz.idex_flush), 32'd1);
    advance();
    hz.MemRead_IDEX = 1'b0;
    cycle("lu_clear");
    hz.MemRead_IDEX = 1'b1; hz.rt_IDEX = 5'd0; hz.rs_IFID = 5'd0;
    settle("lu_r0");
    chk("lu_r0.pc_en", 32'(hz.pc_en), 32'd1);
    advance();

    // Memory wait: 3 frozen cycles, released in the ready cycle
    clear_in();
    hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
    repeat (3) cycle("memwait");
    hz.dmem_ready = 1'b1;
    settle("mem_release");
    chk("mem_release.exmem_en", 32'(hz.exmem_en), 32'd1);
    advance();
    hz.dmem_req = 1'b0;
    cycle("mem_after");

    // Branch beats load-use and jump
    hz.branch_taken_EX = 1'b1; hz.jump_ID = 1'b1;
    hz.MemRead_IDEX = 1'b1; hz.rt_IDEX = 5'd5; hz.rs_IFID = 5'd5;
    settle("br_lu");
    chk("br_lu.pc_en", 32'(hz.pc_en), 32'd1);
    chk("br_lu.idex_flush", 32'(hz.idex_flush), 32'd1);
    advance();

    // Timeout: 4 frozen cycles, abort on the fifth with mem_err set
    clear_in();
    hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
    repeat (4) cycle("to_freeze");
    settle("to_release");
    chk("to_release.pc_en", 32'(hz.pc_en), 32'd1);
    chk("to_release.memwb_flush", 32'(hz.memwb_flush), 32'd1);
    advance();
    hz.dmem_req = 1'b0; hz.dmem_ready = 1'b1;
    settle("to_after");
    chk("to_after.mem_err", 32'(hz.mem_err), 32'd1);
    advance();
    cycle("to_sticky");

    // Reset in the middle of a wait
    hz.dmem_req = 1'b1; hz.dmem_ready = 1'b0;
    repeat (2) cycle("rst_wait");
    rst = 1'b1;
    settle("rst_mid");
    chk("rst_mid.mem_err", 32'(hz.mem_err), 32'd0);
    advance();
    rst = 1'b0;
    clear_in();
    cycle("post_rst");

    // Perf counters: one load-use then one jump
    hz.MemRead_IDEX = 1'b1; hz.rt_IDEX = 5'd7; hz.rt_IFID = 5'd7;
    cycle("perf_lu");
    clear_in();
    hz.jump_ID = 1'b1;
    cycle("perf_jmp");
    clear_in();
    settle("perf");
`ifdef HAZARD_PERF_EN
    chk("perf.stall_one", 32'(hz.stall_cnt), 32'd1);
    chk("perf.flush_one", 32'(hz.flush_cnt), 32'd1);
`endif
    advance();

    // Randomized traffic
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      hz.rs_IFID = 5'($urandom_range(0, 3));
      hz.rt_IFID = 5'($urandom_range(0, 3));
      hz.rs_IDEX = 5'($urandom_range(0, 3));
      hz.rt_IDEX = 5'($urandom_range(0, 3));
      hz.MemRead_IDEX    = 1'($urandom_range(0, 1));
      hz.RegWrite_EXMEM  = 1'($urandom_range(0, 1));
      hz.dest_EXMEM      = 5'($urandom_range(0, 3));
      hz.RegWrite_MEMWB  = 1'($urandom_range(0, 1));
      hz.dest_MEMWB      = 5'($urandom_range(0, 3));
      hz.branch_taken_EX = ($urandom_range(0, 5) == 0);
      hz.jump_ID         = ($urandom_range(0, 5) == 0);
      hz.dmem_req        = 1'($urandom_range(0, 1));
      if (hold == 0 && $urandom_range(0, 29) == 0) hold = 7;
      if (hold > 0) begin
        hz.dmem_ready = 1'b0;
        hold--;
      end else begin
        hz.dmem_ready = ($urandom_range(0, 3) != 0);
      end
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
